// File: rtl/load_store_unit.sv
// Load/store unit: sequences data-memory accesses for the core.
// It aligns the store byte mask and data to the byte offset and drives the synchronous dmem port.
// It waits out the dmem read latency, then returns extended load data, or a fault
// for misaligned or illegal accesses.
module load_store_unit #(
  parameter int ADDR_WIDTH  = 14,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wmask,
  output logic                  dmem_en,
  output logic [3:0]            dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_din,
  input  logic [31:0]           dmem_dout,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Wait-counter preload: WAIT lasts exactly MEM_LATENCY cycles.
  localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  is_load_q, is_load_d;
  logic                  req_ready_q, req_ready_d;
  logic                  dmem_en_q, dmem_en_d;
  logic [3:0]            dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]           dmem_din_q, dmem_din_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_fault_q, resp_fault_d;

  logic                  accept_s;
  logic [1:0]            off_s;
  logic [1:0]            size_s;
  logic                  fault_s;
  logic                  noop_s;
  logic                  unused_addr_s;

  // Upper address bits lie outside the dmem word address and are ignored.
  assign unused_addr_s = ^req_addr[31:ADDR_WIDTH+2];

  // Shift the read word down to the addressed byte/halfword, then extend it per funct3.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extend_load = sh;
      3'b100:  extend_load = {24'd0, sh[7:0]};
      3'b101:  extend_load = {16'd0, sh[15:0]};
      default: extend_load = 32'd0;
    endcase
  endfunction

  // Decode the incoming request: accept handshake, alignment/legality fault, no-op.
  always_comb begin
    accept_s = req_valid & req_ready_q;
    off_s    = req_addr[1:0];
    size_s   = req_funct3[1:0];
    noop_s   = (req_load == req_store);
    fault_s  = (size_s == 2'b11)
             | ((size_s == 2'b01) & off_s[0])
             | ((size_s == 2'b10) & (off_s != 2'b00))
             | (req_load & (req_funct3 == 3'b110));
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    is_load_d    = is_load_q;
    req_ready_d  = 1'b0;
    dmem_en_d    = 1'b0;
    dmem_we_d    = 4'b0000;
    dmem_addr_d  = dmem_addr_q;
    dmem_din_d   = dmem_din_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          off_d     = off_s;
          funct3_d  = req_funct3;
          is_load_d = req_load;
          if (noop_s || fault_s) begin
            // No dmem access; the response carries only the fault flag.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            resp_fault_d = ~noop_s;
          end else if (req_store) begin
            // Stores complete in their single ACCESS cycle.
            state_d      = S_ACCESS;
            dmem_en_d    = 1'b1;
            dmem_we_d    = req_wmask << off_s;
            dmem_addr_d  = req_addr[ADDR_WIDTH+1:2];
            dmem_din_d   = req_wdata << {off_s, 3'b000};
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            resp_fault_d = 1'b0;
          end else begin
            state_d     = S_ACCESS;
            dmem_en_d   = 1'b1;
            dmem_addr_d = req_addr[ADDR_WIDTH+1:2];
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (is_load_q) begin
          state_d = S_WAIT;
          cnt_d   = LAT_INIT;
        end else begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = extend_load(dmem_dout, off_q, funct3_q);
          resp_fault_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and registered-output flops; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      off_q        <= 2'd0;
      funct3_q     <= 3'd0;
      is_load_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      dmem_en_q    <= 1'b0;
      dmem_we_q    <= 4'b0000;
      dmem_addr_q  <= '0;
      dmem_din_q   <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      is_load_q    <= is_load_d;
      req_ready_q  <= req_ready_d;
      dmem_en_q    <= dmem_en_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_din_q   <= dmem_din_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Ready is forced low while reset is asserted and rises as soon as it releases.
  assign req_ready  = req_ready_q & rst_n;
  assign dmem_en    = dmem_en_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_din   = dmem_din_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one DUT at MEM_LATENCY=1 and one at MEM_LATENCY=3,
// both fed the same request stream, each with its own synchronous dmem model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wmask = 4'd0;
  logic [31:0] mem_word = 32'd0;

  logic        d1_ready, d1_en, d1_rv, d1_fault;
  logic [3:0]  d1_we;
  logic [13:0] d1_addr;
  logic [31:0] d1_din, d1_dout, d1_rdata;
  logic        d3_ready, d3_en, d3_rv, d3_fault;
  logic [3:0]  d3_we;
  logic [13:0] d3_addr;
  logic [31:0] d3_din, d3_dout, d3_rdata;
  logic [31:0] p3_0, p3_1, p3_2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(14), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d1_ready),
    .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .dmem_en(d1_en), .dmem_we(d1_we), .dmem_addr(d1_addr), .dmem_din(d1_din),
    .dmem_dout(d1_dout), .resp_valid(d1_rv), .resp_rdata(d1_rdata), .resp_fault(d1_fault));

  load_store_unit #(.ADDR_WIDTH(14), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d3_ready),
    .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .dmem_en(d3_en), .dmem_we(d3_we), .dmem_addr(d3_addr), .dmem_din(d3_din),
    .dmem_dout(d3_dout), .resp_valid(d3_rv), .resp_rdata(d3_rdata), .resp_fault(d3_fault));

  // Latency-1 dmem: read data valid only in the cycle after the read enable.
  always @(posedge clk) d1_dout <= (d1_en && d1_we == 4'b0000) ? mem_word : 32'hDEAD_BEEF;

  // Latency-3 dmem: read data valid only in the third cycle after the read enable.
  always @(posedge clk) begin
    p3_0 <= (d3_en && d3_we == 4'b0000) ? mem_word : 32'hDEAD_BEEF;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign d3_dout = p3_2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_wmask = wm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({d1_ready, d1_en, d1_we, d1_addr, d1_din, d1_rv, d1_rdata, d1_fault} !== 85'd0) begin
      errors++; $display("FAIL reset_outputs: got ready=%b en=%b rv=%b rdata=%h expected all zero",
                         d1_ready, d1_en, d1_rv, d1_rdata);
    end
    step(); step();
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++;
    if (d1_ready !== 1'b1 || d1_rv !== 1'b0 || d1_en !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ready=%b rv=%b en=%b expected 1 0 0", d1_ready, d1_rv, d1_en);
    end
    step();
  endtask

  task automatic test_store_byte();
    drive(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 4'b0001);
    step();
    req_valid = 1'b0;
    vectors++;
    if (d1_en !== 1'b1 || d1_we !== 4'b1000 || d1_din !== 32'hAB00_0000 || d1_addr !== 14'h040 ||
        d1_rv !== 1'b1 || d1_fault !== 1'b0 || d1_ready !== 1'b0) begin
      errors++; $display("FAIL sb_access: got en=%b we=%b din=%h addr=%h rv=%b fault=%b ready=%b expected 1 1000 ab000000 0040 1 0 0",
                         d1_en, d1_we, d1_din, d1_addr, d1_rv, d1_fault, d1_ready);
    end
    step();
    vectors++;
    if (d1_en !== 1'b0 || d1_we !== 4'b0000 || d1_rv !== 1'b0 || d1_ready !== 1'b1 || d1_din !== 32'hAB00_0000) begin
      errors++; $display("FAIL sb_after: got en=%b we=%b rv=%b ready=%b din=%h expected 0 0000 0 1 ab000000",
                         d1_en, d1_we, d1_rv, d1_ready, d1_din);
    end
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
    int lat1 = 0, lat3 = 0, pulses = 0;
    logic [31:0] rd1 = 32'd0, rd3 = 32'd0;
    mem_word = word;
    drive(1'b1, 1'b0, f3, addr, 32'd0, 4'd0);
    step();
    req_valid = 1'b0;
    vectors++;
    if (d1_en !== 1'b1 || d1_we !== 4'b0000) begin
      errors++; $display("FAIL %s_access: got en=%b we=%b expected 1 0000", nm, d1_en, d1_we);
    end
    for (int k = 1; k <= 8; k++) begin
      if (d1_rv) pulses++;
      if (d1_rv && lat1 == 0) begin lat1 = k; rd1 = d1_rdata; end
      if (d3_rv && lat3 == 0) begin lat3 = k; rd3 = d3_rdata; end
      step();
    end
    vectors++;
    if (lat1 != 3 || pulses != 1) begin
      errors++; $display("FAIL %s_lat1: got latency=%0d pulses=%0d expected 3 1", nm, lat1, pulses);
    end
    vectors++;
    if (lat3 != 5) begin
      errors++; $display("FAIL %s_lat3: got latency=%0d expected 5", nm, lat3);
    end
    vectors++;
    if (rd1 !== exp || rd3 !== exp) begin
      errors++; $display("FAIL %s_rdata: got %h / %h expected %h", nm, rd1, rd3, exp);
    end
  endtask

  task automatic test_fault(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic exp_fault);
    drive(ld, st, f3, addr, 32'h1234_5678, 4'b0011);
    step();
    req_valid = 1'b0;
    vectors++;
    if (d1_rv !== 1'b1 || d1_fault !== exp_fault || d1_rdata !== 32'd0 || d1_en !== 1'b0 || d1_we !== 4'b0000) begin
      errors++; $display("FAIL %s_resp: got rv=%b fault=%b rdata=%h en=%b we=%b expected 1 %b 00000000 0 0000",
                         nm, d1_rv, d1_fault, d1_rdata, d1_en, d1_we, exp_fault);
    end
    step();
    vectors++;
    if (d1_rv !== 1'b0 || d1_fault !== exp_fault || d1_ready !== 1'b1 || d1_en !== 1'b0) begin
      errors++; $display("FAIL %s_hold: got rv=%b fault=%b ready=%b en=%b expected 0 %b 1 0",
                         nm, d1_rv, d1_fault, d1_ready, d1_en, exp_fault);
    end
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    int done = 0, bad = 0;
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 4'b1111);
    for (int i = 0; i < 6; i++) begin
      step();
      if (d1_ready !== (i % 2 == 1) || d1_rv !== (i % 2 == 0)) bad++;
      if (d1_rv) done++;
    end
    vectors++;
    if (done != 3 || bad != 0) begin
      errors++; $display("FAIL b2b_stores: got completions=%0d bad_cycles=%0d expected 3 0", done, bad);
    end
    step();
    mem_word = 32'hCAFE_1234;
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 4'd0);
    step();
    vectors++;
    if (d1_ready !== 1'b1 || d1_en !== 1'b0 || d1_rv !== 1'b0) begin
      errors++; $display("FAIL b2b_lw_blocked: got ready=%b en=%b rv=%b expected 1 0 0", d1_ready, d1_en, d1_rv);
    end
    step();
    req_valid = 1'b0;
    vectors++;
    if (d1_en !== 1'b1 || d1_we !== 4'b0000 || d1_addr !== 14'h008) begin
      errors++; $display("FAIL b2b_lw_accept: got en=%b we=%b addr=%h expected 1 0000 0008", d1_en, d1_we, d1_addr);
    end
    step(); step();
    vectors++;
    if (d1_rv !== 1'b1 || d1_rdata !== 32'hCAFE_1234 || d1_fault !== 1'b0) begin
      errors++; $display("FAIL b2b_lw_resp: got rv=%b rdata=%h fault=%b expected 1 cafe1234 0", d1_rv, d1_rdata, d1_fault);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_reset_in_wait();
    int stray = 0;
    mem_word = 32'h0BAD_F00D;
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'd0, 4'd0);
    step();
    req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({d1_ready, d1_en, d1_we, d1_addr, d1_din, d1_rv, d1_rdata, d1_fault} !== 85'd0) begin
      errors++; $display("FAIL rst_wait_outputs: got ready=%b en=%b rv=%b rdata=%h expected all zero",
                         d1_ready, d1_en, d1_rv, d1_rdata);
    end
    step();
    @(negedge clk); rst_n = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      if (d1_rv || d3_rv) stray++;
      step();
    end
    vectors++;
    if (stray != 0 || d1_rdata !== 32'd0) begin
      errors++; $display("FAIL rst_wait_abandon: got stray=%0d rdata=%h expected 0 00000000", stray, d1_rdata);
    end
    test_load("lw_after_rst", 3'b010, 32'h0000_0004, 32'h5566_7788, 32'h5566_7788);
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load("lb", 3'b000, 32'h0000_0102, 32'h1280_FF34, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h0000_0102, 32'h1280_FF34, 32'h0000_0080);
    test_fault("noop", 1'b1, 1'b1, 3'b010, 32'h0000_0000, 1'b0);
    test_load("lh", 3'b001, 32'h0000_0002, 32'h8001_7F00, 32'hFFFF_8001);
    test_fault("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h0000_0006, 1'b1);
    test_fault("sh_misalign", 1'b0, 1'b1, 3'b001, 32'h0000_0001, 1'b1);
    test_fault("load_f3_110", 1'b1, 1'b0, 3'b110, 32'h0000_0000, 1'b1);
    test_back_to_back();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
